// File: rtl/packet_lane_buffer_pkg.sv
// Shared types and elaboration-time helpers for the packet lane buffer.
package packet_lane_buffer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PKT  = 2'd1,
        S_DROP = 2'd2
    } wr_state_e;

    function automatic bit lane_width_ok(input int axi_width, input int lane_width);
        return (lane_width > 0) && (axi_width >= lane_width) && ((axi_width % lane_width) == 0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/packet_lane_buffer_pkt_sdp_ram.sv
// Inferred simple-dual-port beat storage: one write port, one registered read port.
module pkt_sdp_ram #(
    parameter  int WIDTH = 73,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read data only changes on a read request so the consumer may hold it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/packet_lane_buffer.sv
// Packet buffer between the wide MAC stream and the per-lane parser; store-and-forward
// with whole-packet drop or cut-through with backpressure, plus packet/drop counters.
module packet_lane_buffer
    import packet_lane_buffer_pkg::*;
#(
    parameter  int AXI_WIDTH  = 64,
    parameter  int LANE_WIDTH = 8,
    parameter  int DEPTH      = 512,
    parameter  int STORE_FWD  = 1,
    parameter  int CNT_WIDTH  = 16,
    localparam int NUM_LANES  = AXI_WIDTH / LANE_WIDTH,
    localparam int PTR_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [AXI_WIDTH-1:0]  tdata_i,
    input  logic [NUM_LANES-1:0]  tkeep_i,
    input  logic                  tlast_i,
    input  logic                  tvalid_i,
    output logic                  tready_o,
    output logic [LANE_WIDTH-1:0] pkt_tdata_o [NUM_LANES],
    output logic [NUM_LANES-1:0]  pkt_tkeep_o,
    output logic                  pkt_tlast_o,
    output logic                  pkt_tvalid_o,
    input  logic                  pkt_tready_i,
    output logic [PTR_W-1:0]      fill_level_o,
    output logic [CNT_WIDTH-1:0]  pkt_count_o,
    output logic [CNT_WIDTH-1:0]  drop_count_o
);

    localparam int AW = PTR_W - 1;
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef struct packed {
        logic                 last;
        logic [NUM_LANES-1:0] keep;
        logic [AXI_WIDTH-1:0] data;
    } beat_t;

    if (!lane_width_ok(AXI_WIDTH, LANE_WIDTH)) begin : g_bad_lane
        $error("AXI_WIDTH must be a non-zero multiple of LANE_WIDTH");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end

    wr_state_e          state_q, state_d;
    logic               en_q;
    logic [PTR_W-1:0]   wr_q, wr_d, commit_q, commit_d;
    logic [PTR_W-1:0]   rd_q, rd_d, fetch_q, fetch_d, fill_q;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, drop_cnt_q;
    logic               ram_vld_q;
    logic [1:0]         cnt_q, cnt_d;
    beat_t              head_q, head_d, tail_q, tail_d;

    logic [PTR_W-1:0]   used_w, limit_w;
    logic               full_w, accept_w, we_w, pkt_inc_w, drop_inc_w;
    logic               pop_w, issue_w;
    beat_t              wr_beat_w, ram_beat_w;
    logic [$bits(beat_t)-1:0] ram_rdata_w;

    assign used_w   = wr_q - rd_q;
    assign full_w   = (used_w == PTR_W'(DEPTH));
    assign tready_o = en_q && ((STORE_FWD != 0) || !full_w);
    assign accept_w = tvalid_i && tready_o;

    // In cut-through mode accept implies not full, so the rewind/DROP path is unreachable.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        commit_d   = commit_q;
        we_w       = 1'b0;
        pkt_inc_w  = 1'b0;
        drop_inc_w = 1'b0;
        if (accept_w) begin
            case (state_q)
                S_IDLE, S_PKT: begin
                    if (full_w) begin
                        wr_d = commit_q;
                        if (tlast_i) begin
                            drop_inc_w = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        we_w = 1'b1;
                        wr_d = wr_q + PTR_ONE;
                        if (tlast_i) begin
                            commit_d  = wr_q + PTR_ONE;
                            pkt_inc_w = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_PKT;
                        end
                    end
                end
                S_DROP: begin
                    if (tlast_i) begin
                        drop_inc_w = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // rd_q frees RAM entries only when the consumer takes a beat; fetch_q runs ahead into the skid.
    assign limit_w      = (STORE_FWD != 0) ? commit_q : wr_q;
    assign pkt_tvalid_o = (cnt_q != 2'd0);
    assign pop_w        = pkt_tvalid_o && pkt_tready_i;
    assign ram_beat_w   = beat_t'(ram_rdata_w);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop_w) begin
            head_d = tail_q;
            cnt_d  = cnt_d - 2'd1;
        end
        if (ram_vld_q) begin
            if (cnt_d == 2'd0) begin
                head_d = ram_beat_w;
            end else begin
                tail_d = ram_beat_w;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    assign issue_w = (fetch_q != limit_w) && (cnt_d <= 2'd1);
    assign rd_d    = rd_q + PTR_W'(pop_w);
    assign fetch_d = fetch_q + PTR_W'(issue_w);

    assign wr_beat_w = '{last: tlast_i, keep: tkeep_i, data: tdata_i};

    pkt_sdp_ram #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we_w),
        .waddr_i (wr_q[AW-1:0]),
        .wdata_i (wr_beat_w),
        .re_i    (issue_w),
        .raddr_i (fetch_q[AW-1:0]),
        .rdata_o (ram_rdata_w)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            wr_q       <= '0;
            commit_q   <= '0;
            rd_q       <= '0;
            fetch_q    <= '0;
            fill_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ram_vld_q  <= 1'b0;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= 1'b1;
            wr_q      <= wr_d;
            commit_q  <= commit_d;
            rd_q      <= rd_d;
            fetch_q   <= fetch_d;
            fill_q    <= wr_d - rd_d;
            if (pkt_inc_w && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
            end
            if (drop_inc_w && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_ONE;
            end
            ram_vld_q <= issue_w;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            pkt_tdata_o[i] = head_q.data[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    assign pkt_tkeep_o  = head_q.keep;
    assign pkt_tlast_o  = head_q.last;
    assign fill_level_o = fill_q;
    assign pkt_count_o  = pkt_cnt_q;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_packet_lane_buffer.sv
// Bench for packet_lane_buffer: a store-and-forward and a cut-through instance (DEPTH=16)
// checked against a queue-based packet model, a latency vector table and directed corner cases.
module tb_packet_lane_buffer;

    localparam int DEPTH = 16;
    localparam int CW    = 3;
    localparam int SAT   = (1 << CW) - 1;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        bit          v;
        logic [63:0] d;
        logic [7:0]  k;
        bit          l;
        bit          rdy;
        bit          ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        bit          el;
        int          epc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        pkt_tready = 1'b0;

    logic        sf_tready, ct_tready, sf_pvalid, ct_pvalid, sf_plast, ct_plast;
    logic [7:0]  sf_lanes [8];
    logic [7:0]  ct_lanes [8];
    logic [7:0]  sf_pkeep, ct_pkeep;
    logic [4:0]  sf_fill, ct_fill;
    logic [CW-1:0] sf_pc, ct_pc, sf_dc, ct_dc;

    logic        tready_v, pvalid_v, plast_v;
    logic [63:0] pdata_v;
    logic [7:0]  pkeep_v;
    logic [4:0]  fill_v;
    logic [CW-1:0] pc_v, dc_v;

    always #5 clk = ~clk;

    packet_lane_buffer #(.AXI_WIDTH(64), .LANE_WIDTH(8), .DEPTH(DEPTH), .STORE_FWD(1), .CNT_WIDTH(CW)) u_sf (
        .clk_i(clk), .rst_ni(rst_n), .tdata_i(tdata), .tkeep_i(tkeep), .tlast_i(tlast),
        .tvalid_i(tvalid & ~sel), .tready_o(sf_tready), .pkt_tdata_o(sf_lanes), .pkt_tkeep_o(sf_pkeep),
        .pkt_tlast_o(sf_plast), .pkt_tvalid_o(sf_pvalid), .pkt_tready_i(pkt_tready & ~sel),
        .fill_level_o(sf_fill), .pkt_count_o(sf_pc), .drop_count_o(sf_dc));

    packet_lane_buffer #(.AXI_WIDTH(64), .LANE_WIDTH(8), .DEPTH(DEPTH), .STORE_FWD(0), .CNT_WIDTH(CW)) u_ct (
        .clk_i(clk), .rst_ni(rst_n), .tdata_i(tdata), .tkeep_i(tkeep), .tlast_i(tlast),
        .tvalid_i(tvalid & sel), .tready_o(ct_tready), .pkt_tdata_o(ct_lanes), .pkt_tkeep_o(ct_pkeep),
        .pkt_tlast_o(ct_plast), .pkt_tvalid_o(ct_pvalid), .pkt_tready_i(pkt_tready & sel),
        .fill_level_o(ct_fill), .pkt_count_o(ct_pc), .drop_count_o(ct_dc));

    always_comb begin
        pdata_v = '0;
        for (int i = 0; i < 8; i++) begin
            pdata_v[i*8 +: 8] = sel ? ct_lanes[i] : sf_lanes[i];
        end
        tready_v = sel ? ct_tready : sf_tready;
        pvalid_v = sel ? ct_pvalid : sf_pvalid;
        plast_v  = sel ? ct_plast  : sf_plast;
        pkeep_v  = sel ? ct_pkeep  : sf_pkeep;
        fill_v   = sel ? ct_fill   : sf_fill;
        pc_v     = sel ? ct_pc     : sf_pc;
        dc_v     = sel ? ct_dc     : sf_dc;
    end

    int checks = 0;
    int failures = 0;

    beat_t exp_q[$];
    beat_t cur_q[$];
    bit    dropping;
    int    m_pkts, m_drops, n_out;
    bit    stalled;
    beat_t hold;
    bit    obs_valid, obs_tready;
    logic [63:0] obs_data;
    logic [7:0]  obs_keep;
    logic        obs_last;
    int    obs_fill, obs_pc, obs_dc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k, input bit l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        cur_q.delete();
        dropping = 1'b0;
        m_pkts   = 0;
        m_drops  = 0;
        n_out    = 0;
        stalled  = 1'b0;
    endtask

    // A packet is readable as a whole once its last beat is stored (store-and-forward),
    // or beat by beat (cut-through); storage holds DEPTH unread beats.
    task automatic model_accept(input beat_t b, input int used);
        if (sel) begin
            exp_q.push_back(b);
            if (b.last && m_pkts < SAT) m_pkts++;
        end else if (dropping) begin
            if (b.last) begin
                dropping = 1'b0;
                if (m_drops < SAT) m_drops++;
            end
        end else if (used == DEPTH) begin
            cur_q.delete();
            if (b.last) begin
                if (m_drops < SAT) m_drops++;
            end else begin
                dropping = 1'b1;
            end
        end else begin
            cur_q.push_back(b);
            if (b.last) begin
                foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                cur_q.delete();
                if (m_pkts < SAT) m_pkts++;
            end
        end
    endtask

    task automatic step(input bit v, input beat_t b, input bit rdy, output bit acc);
        bit pop;
        int used;
        @(negedge clk);
        tvalid = v;
        tdata = b.data;
        tkeep = b.keep;
        tlast = b.last;
        pkt_tready = rdy;
        #1;
        used = exp_q.size() + cur_q.size();
        acc = v && tready_v;
        pop = pvalid_v && rdy;
        obs_valid = pvalid_v;
        obs_tready = tready_v;
        obs_data = pdata_v;
        obs_keep = pkeep_v;
        obs_last = plast_v;
        obs_fill = int'(fill_v);
        obs_pc = int'(pc_v);
        obs_dc = int'(dc_v);
        chk("tready", tready_v, sel ? (used != DEPTH) : 1'b1);
        chk("fill_level", fill_v, used);
        chk("pkt_count", pc_v, m_pkts);
        chk("drop_count", dc_v, m_drops);
        if (stalled) begin
            chk("stall_valid", pvalid_v, 1'b1);
            chk("stall_data", pdata_v, hold.data);
            chk("stall_keep", pkeep_v, hold.keep);
            chk("stall_last", plast_v, hold.last);
        end
        if (pvalid_v) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", pvalid_v, 1'b0);
            end else begin
                chk("out_data", pdata_v, exp_q[0].data);
                chk("out_keep", pkeep_v, exp_q[0].keep);
                chk("out_last", plast_v, exp_q[0].last);
            end
        end
        stalled = pvalid_v && !rdy;
        hold = mk(pdata_v, pkeep_v, plast_v);
        if (pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_out++;
        end
        if (acc) model_accept(b, used);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tdata = '0;
        tkeep = '0;
        pkt_tready = 1'b0;
        #1;
        chk("rst_tready", tready_v, 1'b0);
        chk("rst_pvalid", pvalid_v, 1'b0);
        chk("rst_data", pdata_v, 64'h0);
        chk("rst_keep", pkeep_v, 8'h0);
        chk("rst_last", plast_v, 1'b0);
        chk("rst_fill", fill_v, 0);
        chk("rst_pc", pc_v, 0);
        chk("rst_dc", dc_v, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_tready", tready_v, 1'b0);
        model_clear();
        @(posedge clk);
    endtask

    task automatic send_pkt(input int len, input bit rnd, input bit rdy_fixed, input logic [31:0] tag);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            int guard;
            bit acc;
            bit v;
            bit r;
            guard = 0;
            acc = 1'b0;
            if (rnd) b = mk({$urandom(), $urandom()}, 8'($urandom()), i == len - 1);
            else     b = mk({tag, 32'(i)}, 8'hFF, i == len - 1);
            while (!acc) begin
                v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                r = rnd ? 1'($urandom_range(0, 1)) : rdy_fixed;
                step(v, b, r, acc);
                guard++;
                if (!acc && guard > 400) begin
                    chk("send_timeout_tready", obs_tready, 1'b1);
                    return;
                end
            end
        end
    endtask

    task automatic drain(output int nbeats, output int span);
        int first;
        int lastv;
        bit acc;
        first = -1;
        lastv = -1;
        nbeats = 0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            step(1'b0, mk(64'h0, 8'h0, 1'b0), 1'b1, acc);
            if (obs_valid) begin
                nbeats++;
                if (first < 0) first = i;
                lastv = i;
            end
        end
        chk("drain_left", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) step(1'b0, mk(64'h0, 8'h0, 1'b0), 1'b1, acc);
        span = (first < 0) ? 0 : lastv - first + 1;
    endtask

    initial begin
        vec_t vt[9];
        bit acc;
        int nb, sp, n_acc;

        vt[0] = '{1, 64'h0706050403020100, 8'hFF, 0, 1, 0, 64'h0, 8'h00, 0, 0};
        vt[1] = '{1, 64'h0F0E0D0C0B0A0908, 8'hFF, 0, 1, 0, 64'h0, 8'h00, 0, 0};
        vt[2] = '{1, 64'h1716151413121110, 8'h0F, 1, 1, 0, 64'h0, 8'h00, 0, 0};
        vt[3] = '{0, 64'h0, 8'h00, 0, 1, 0, 64'h0, 8'h00, 0, 1};
        vt[4] = '{0, 64'h0, 8'h00, 0, 1, 0, 64'h0, 8'h00, 0, 1};
        vt[5] = '{0, 64'h0, 8'h00, 0, 1, 1, 64'h0706050403020100, 8'hFF, 0, 1};
        vt[6] = '{0, 64'h0, 8'h00, 0, 1, 1, 64'h0F0E0D0C0B0A0908, 8'hFF, 0, 1};
        vt[7] = '{0, 64'h0, 8'h00, 0, 1, 1, 64'h1716151413121110, 8'h0F, 1, 1};
        vt[8] = '{0, 64'h0, 8'h00, 0, 1, 0, 64'h0, 8'h00, 0, 1};

        // Store-and-forward latency and lane mapping of a 3-beat packet
        sel = 1'b0;
        do_reset();
        for (int r = 0; r < 9; r++) begin
            step(vt[r].v, mk(vt[r].d, vt[r].k, vt[r].l), vt[r].rdy, acc);
            chk($sformatf("vec%0d_valid", r), obs_valid, vt[r].ev);
            chk($sformatf("vec%0d_pc", r), obs_pc, vt[r].epc);
            if (vt[r].ev) begin
                chk($sformatf("vec%0d_data", r), obs_data, vt[r].ed);
                chk($sformatf("vec%0d_lane0", r), obs_data[7:0], vt[r].ed[7:0]);
                chk($sformatf("vec%0d_keep", r), obs_keep, vt[r].ek);
                chk($sformatf("vec%0d_last", r), obs_last, vt[r].el);
            end
        end

        // Overflow drop: A fits, B overflows at its 7th beat and is rewound
        sel = 1'b0;
        do_reset();
        send_pkt(10, 1'b0, 1'b0, 32'hA);
        send_pkt(10, 1'b0, 1'b0, 32'hB);
        step(1'b0, mk(64'h0, 8'h0, 1'b0), 1'b0, acc);
        chk("ab_fill", obs_fill, 10);
        chk("ab_drop", obs_dc, 1);
        chk("ab_pkts", obs_pc, 1);
        drain(nb, sp);
        chk("ab_out_beats", n_out, 10);
        chk("ab_burst_span", sp, 10);

        // Packet longer than the buffer, then a short one
        sel = 1'b0;
        do_reset();
        send_pkt(20, 1'b0, 1'b1, 32'h20);
        send_pkt(2, 1'b0, 1'b1, 32'h2);
        drain(nb, sp);
        chk("big_drop", obs_dc, 1);
        chk("big_pkts", obs_pc, 1);
        chk("big_out", n_out, 2);

        // Cut-through backpressure
        sel = 1'b1;
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, mk({32'hC7, 32'(n_acc)}, 8'hFF, n_acc == 19), 1'b0, acc);
            if (acc) n_acc++;
        end
        chk("ct_accepts_stalled", n_acc, 16);
        chk("ct_tready_low", obs_tready, 1'b0);
        for (int i = 0; i < 100 && n_acc < 20; i++) begin
            step(1'b1, mk({32'hC7, 32'(n_acc)}, 8'hFF, n_acc == 19), 1'b1, acc);
            if (acc) n_acc++;
        end
        drain(nb, sp);
        chk("ct_total_in", n_acc, 20);
        chk("ct_total_out", n_out, 20);
        chk("ct_pkts", obs_pc, 1);
        chk("ct_drops", obs_dc, 0);

        // Randomised back-to-back packets against the model, both modes
        for (int m = 0; m < 2; m++) begin
            sel = (m == 1);
            do_reset();
            for (int p = 0; p < 40; p++) begin
                send_pkt(($urandom_range(0, 1) != 0) ? $urandom_range(1, 8) : $urandom_range(1, 64),
                         1'b1, 1'b0, 32'h0);
            end
            drain(nb, sp);
        end

        // Asynchronous reset in the middle of a packet
        sel = 1'b0;
        do_reset();
        send_pkt(3, 1'b0, 1'b0, 32'h51);
        for (int i = 0; i < 2; i++) step(1'b1, mk({32'h52, 32'(i)}, 8'hFF, 1'b0), 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, mk(64'h0, 8'h0, 1'b0), 1'b0, acc);
        chk("mr_fill_pre", obs_fill, 5);
        chk("mr_valid_pre", obs_valid, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_pvalid", pvalid_v, 1'b0);
        chk("mr_tready", tready_v, 1'b0);
        chk("mr_data", pdata_v, 64'h0);
        chk("mr_keep", pkeep_v, 8'h0);
        chk("mr_fill", fill_v, 0);
        chk("mr_pc", pc_v, 0);
        do_reset();
        send_pkt(2, 1'b0, 1'b1, 32'h53);
        drain(nb, sp);
        chk("mr_after_pkts", obs_pc, 1);
        chk("mr_after_drops", obs_dc, 0);
        chk("mr_after_out", n_out, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
